uart_tx_sched: RTL

Byte scheduler that shares the single `uart_tx` serializer between two requesters: port A (the echo path fed from `uart_rx`) and port B (the on-chip message/status source). Each port has its own small FIFO; a round-robin arbiter pops one byte at a time, issues a one-cycle start strobe to the serializer and waits for its `tx_done`. A watchdog aborts a transfer if `tx_done` never arrives. Sits between the requesters and `uart_tx` in the top level, on the `SB_HFOSC` clock domain.

---
 rtl/uart_tx_sched.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// Two-port byte scheduler in front of a single UART serializer: per-port FIFOs,
// round-robin pick, one-cycle start strobe, and a watchdog on the serializer's done pulse.

module uart_tx_sched_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       empty,
   output logic       full
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
endmodule

// state   | meaning
// IDLE    | waiting for a queued byte; pops the chosen port's head into tx_data
// START   | tx_start strobe cycle; tx_done ignored
// WAIT    | waiting for tx_done, watchdog running
module uart_tx_sched #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] a_data,
   input  logic       a_valid,
   output logic       a_ready,
   input  logic [7:0] b_data,
   input  logic       b_valid,
   output logic       b_ready,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_done,
   output logic       busy,
   output logic       grant,
   output logic       timeout_err
);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_start_q, tx_start_d;
   logic          busy_q, busy_d;
   logic          grant_q, grant_d;
   logic          err_q, err_d;
   logic [TW-1:0] wd_q, wd_d;

   logic       a_push, b_push, a_pop, b_pop;
   logic       a_empty, b_empty, a_full, b_full;
   logic [7:0] a_head, b_head;
   logic       sel_b;

   assign a_ready = !a_full && !rst;
   assign b_ready = !b_full && !rst;
   assign a_push  = a_valid && a_ready;
   assign b_push  = b_valid && b_ready;

   uart_tx_sched_fifo #(.DEPTH(DEPTH)) u_fifo_a (
      .clk       (clk),
      .rst       (rst),
      .push      (a_push),
      .push_data (a_data),
      .pop       (a_pop),
      .head      (a_head),
      .empty     (a_empty),
      .full      (a_full)
   );

   uart_tx_sched_fifo #(.DEPTH(DEPTH)) u_fifo_b (
      .clk       (clk),
      .rst       (rst),
      .push      (b_push),
      .push_data (b_data),
      .pop       (b_pop),
      .head      (b_head),
      .empty     (b_empty),
      .full      (b_full)
   );

   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      grant_d   = grant_q;
      err_d     = err_q;
      wd_d      = wd_q;
      a_pop     = 1'b0;
      b_pop     = 1'b0;
      sel_b     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!a_empty || !b_empty) begin
               // On a tie, serve the port that was not served last.
               sel_b     = (!a_empty && !b_empty) ? !grant_q : !b_empty;
               a_pop     = !sel_b;
               b_pop     = sel_b;
               tx_data_d = sel_b ? b_head : a_head;
               grant_d   = sel_b;
               state_d   = S_START;
            end
         end
         S_START: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tx_done) begin
               state_d = S_IDLE;
            end else if (wd_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wd_d = wd_q + TW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      tx_start_d = (state_d == S_START);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         grant_q    <= 1'b1;
         err_q      <= 1'b0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         grant_q    <= grant_d;
         err_q      <= err_d;
         wd_q       <= wd_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign busy        = busy_q;
   assign grant       = grant_q;
   assign timeout_err = err_q;
endmodule
